// File: rtl/seg_disp_pkg.sv
//==============================================================================
// seg_disp_pkg - glyphs, digit map and mode encoding for the 7-seg display, rev 1.0
//==============================================================================
`default_nettype none

package seg_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [2:0] DIG_SEC_U  = 3'd0;
  localparam logic [2:0] DIG_SEC_T  = 3'd1;
  localparam logic [2:0] DIG_MIN_U  = 3'd2;
  localparam logic [2:0] DIG_MIN_T  = 3'd3;
  localparam logic [2:0] DIG_HOUR_U = 3'd4;
  localparam logic [2:0] DIG_HOUR_T = 3'd5;
  localparam logic [2:0] DIG_SPACE  = 3'd6;
  localparam logic [2:0] DIG_WEEK   = 3'd7;

  localparam logic [3:0] MODE_SET = 4'd1;

  typedef struct packed {
    logic [3:0] week;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
  } snap_t;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = SEG_0;
      4'd1:    digit_glyph = SEG_1;
      4'd2:    digit_glyph = SEG_2;
      4'd3:    digit_glyph = SEG_3;
      4'd4:    digit_glyph = SEG_4;
      4'd5:    digit_glyph = SEG_5;
      4'd6:    digit_glyph = SEG_6;
      4'd7:    digit_glyph = SEG_7;
      4'd8:    digit_glyph = SEG_8;
      4'd9:    digit_glyph = SEG_9;
      default: digit_glyph = SEG_DASH;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2dec_2dig.sv
//==============================================================================
// bin2dec_2dig - 6-bit binary to two decimal digits, flags values above 59, rev 1.0
//==============================================================================
`default_nettype none

module bin2dec_2dig (
  input  logic [5:0] val_i,
  output logic [3:0] tens_o,
  output logic [3:0] units_o,
  output logic       oor_o
);

  logic [3:0] off_w;

  // units = val - 10*tens; only the low nibble matters since the result is < 10,
  // so off_w holds (10*tens) mod 16
  always_comb begin
    tens_o = 4'd0;
    off_w  = 4'd0;
    if (val_i >= 6'd60) begin
      tens_o = 4'd6; off_w = 4'd12;
    end else if (val_i >= 6'd50) begin
      tens_o = 4'd5; off_w = 4'd2;
    end else if (val_i >= 6'd40) begin
      tens_o = 4'd4; off_w = 4'd8;
    end else if (val_i >= 6'd30) begin
      tens_o = 4'd3; off_w = 4'd14;
    end else if (val_i >= 6'd20) begin
      tens_o = 4'd2; off_w = 4'd4;
    end else if (val_i >= 6'd10) begin
      tens_o = 4'd1; off_w = 4'd10;
    end
    units_o = val_i[3:0] - off_w;
  end

  assign oor_o = (val_i > 6'd59);

endmodule

`default_nettype wire

// File: rtl/seg_scan_display.sv
//==============================================================================
// seg_scan_display - scanned 8-digit common-anode time/weekday display, rev 1.0
//==============================================================================
`default_nettype none

module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic [3:0] state_mode,
  input  logic [3:0] week_day,
  input  logic [7:0] hour_time,
  input  logic [7:0] minute_time,
  input  logic [7:0] second_time,
  output logic [7:0] seg,
  output logic [7:0] dig_sel
);

  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int PRESC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic               first_q;
  snap_t              snap_q;
  logic [7:0]         seg_q, seg_d;
  logic [7:0]         dig_sel_q, dig_sel_d;

  logic       presc_wrap, snap_en;
  logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
  logic       hr_oor6, mn_oor6, sc_oor6;
  logic       hour_bad, min_bad, sec_bad, week_ok;
  logic [7:0] glyph_w;
  logic       dp_w, blank_w;

  bin2dec_2dig u_hour (.val_i(snap_q.hour[5:0]),   .tens_o(hr_t), .units_o(hr_u), .oor_o(hr_oor6));
  bin2dec_2dig u_min  (.val_i(snap_q.minute[5:0]), .tens_o(mn_t), .units_o(mn_u), .oor_o(mn_oor6));
  bin2dec_2dig u_sec  (.val_i(snap_q.second[5:0]), .tens_o(sc_t), .units_o(sc_u), .oor_o(sc_oor6));

  assign hour_bad = hr_oor6 | (snap_q.hour > 8'd23);
  assign min_bad  = mn_oor6 | (|snap_q.minute[7:6]);
  assign sec_bad  = sc_oor6 | (|snap_q.second[7:6]);
  assign week_ok  = (snap_q.week >= 4'd1) && (snap_q.week <= 4'd7);

  always_comb begin
    presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = presc_wrap ? idx_q + 3'd1 : idx_q;
    // A new snapshot lands exactly as the index wraps back to digit 0
    snap_en    = first_q | (presc_wrap && (idx_q == DIG_WEEK));
    phase_d    = phase_q;
    bcnt_d     = bcnt_q + 1'b1;
    if (bcnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    glyph_w = SEG_BLANK;
    case (idx_q)
      DIG_WEEK:   glyph_w = week_ok  ? digit_glyph(snap_q.week) : SEG_DASH;
      DIG_SPACE:  glyph_w = SEG_BLANK;
      DIG_HOUR_T: glyph_w = hour_bad ? SEG_DASH : digit_glyph(hr_t);
      DIG_HOUR_U: glyph_w = hour_bad ? SEG_DASH : digit_glyph(hr_u);
      DIG_MIN_T:  glyph_w = min_bad  ? SEG_DASH : digit_glyph(mn_t);
      DIG_MIN_U:  glyph_w = min_bad  ? SEG_DASH : digit_glyph(mn_u);
      DIG_SEC_T:  glyph_w = sec_bad  ? SEG_DASH : digit_glyph(sc_t);
      default:    glyph_w = sec_bad  ? SEG_DASH : digit_glyph(sc_u);
    endcase
    dp_w    = (idx_q == DIG_HOUR_U) || (idx_q == DIG_MIN_U);
    blank_w = (state_mode == MODE_SET) && !phase_q &&
              (idx_q >= DIG_MIN_U) && (idx_q <= DIG_HOUR_T);

    seg_d     = SEG_BLANK;
    dig_sel_d = 8'hFF;
    if (presc_q != '0) begin
      dig_sel_d = ~(8'd1 << idx_q);
      if (!blank_w) begin
        seg_d = dp_w ? (glyph_w & 8'h7F) : glyph_w;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= 3'd0;
      bcnt_q    <= '0;
      phase_q   <= 1'b1;
      first_q   <= 1'b1;
      snap_q    <= '0;
      seg_q     <= 8'hFF;
      dig_sel_q <= 8'hFF;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      first_q   <= 1'b0;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
      if (snap_en) begin
        snap_q <= '{week: week_day, hour: hour_time, minute: minute_time, second: second_time};
      end
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_display.sv
//==============================================================================
// tb_seg_scan_display - scoreboard bench for seg_scan_display, rev 1.0
//==============================================================================
`default_nettype none

module tb_seg_scan_display;

  localparam int SD = 10;
  localparam int BD = 20;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] state_mode = 4'd0;
  logic [3:0] week_day   = 4'd3;
  logic [7:0] hour_time  = 8'd12;
  logic [7:0] minute_time = 8'd59;
  logic [7:0] second_time = 8'd0;
  logic [7:0] seg;
  logic [7:0] dig_sel;

  seg_scan_display #(.CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(25)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .state_mode(state_mode), .week_day(week_day),
    .hour_time(hour_time), .minute_time(minute_time), .second_time(second_time),
    .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk_50M = ~clk_50M;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] dig;
    logic [7:0] sg;
    int         n;
  } exp_t;
  exp_t q[$];

  logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // Reference model state
  int m_presc, m_idx, m_bcnt, m_n, m_wk, m_hr, m_mn, m_sc;
  bit m_phase, m_first;

  function automatic logic [7:0] exp_glyph(input int idx);
    logic [7:0] g;
    case (idx)
      7: g = (m_wk >= 1 && m_wk <= 7) ? tbl[m_wk] : 8'hBF;
      6: g = 8'hFF;
      5: g = (m_hr > 23) ? 8'hBF : tbl[m_hr / 10];
      4: g = ((m_hr > 23) ? 8'hBF : tbl[m_hr % 10]) & 8'h7F;
      3: g = (m_mn > 59) ? 8'hBF : tbl[m_mn / 10];
      2: g = ((m_mn > 59) ? 8'hBF : tbl[m_mn % 10]) & 8'h7F;
      1: g = (m_sc > 59) ? 8'hBF : tbl[m_sc / 10];
      default: g = (m_sc > 59) ? 8'hBF : tbl[m_sc % 10];
    endcase
    if (state_mode == 4'd1 && !m_phase && idx >= 2 && idx <= 5) g = 8'hFF;
    return g;
  endfunction

  always @(posedge clk_50M or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_presc = 0; m_idx = 0; m_bcnt = 0; m_n = 0;
      m_phase = 1'b1; m_first = 1'b1;
      m_wk = 0; m_hr = 0; m_mn = 0; m_sc = 0;
      q.delete();
    end else begin
      e.n = m_n;
      if (m_presc == 0) begin
        e.dig = 8'hFF; e.sg = 8'hFF;
      end else begin
        e.dig = ~(8'd1 << m_idx);
        e.sg  = exp_glyph(m_idx);
      end
      q.push_back(e);
      if (m_first || (m_presc == SD - 1 && m_idx == 7)) begin
        m_wk = int'(week_day); m_hr = int'(hour_time);
        m_mn = int'(minute_time); m_sc = int'(second_time);
      end
      m_first = 1'b0;
      m_n++;
      if (m_presc == SD - 1) begin
        m_presc = 0; m_idx = (m_idx + 1) % 8;
      end else m_presc++;
      if (m_bcnt == BD - 1) begin
        m_bcnt = 0; m_phase = !m_phase;
      end else m_bcnt++;
    end
  end

  logic [7:0] last_seg [8];

  always @(negedge clk_50M) begin
    exp_t e;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      check("dig_sel", dig_sel, e.dig);
      check("seg", seg, e.sg);
      check("onehot", 32'($countones(~dig_sel) <= 1), 32'd1);
      if (e.n % SD == 0) check("guard", dig_sel, 8'hFF);
      for (int i = 0; i < 8; i++) if (!dig_sel[i]) last_seg[i] = seg;
    end
  end

  task automatic set_time(input int wk, input int hr, input int mn, input int sc);
    week_day = 4'(wk); hour_time = 8'(hr); minute_time = 8'(mn); second_time = 8'(sc);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk_50M);
    check("rst_seg", seg, 8'hFF);
    check("rst_dig", dig_sel, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk_50M);
    check("c1_dig", dig_sel, 8'hFF);
    @(negedge clk_50M);
    check("c2_dig", dig_sel, 8'hFE);
    check("c2_seg", seg, 8'hC0);
    repeat (85) @(negedge clk_50M);
    check("d5_hour_t", last_seg[5], 8'hF9);
    check("d4_hour_u", last_seg[4], 8'h24);
    check("d7_week", last_seg[7], 8'hB0);

    set_time(5, 23, 59, 59);
    repeat (170) @(negedge clk_50M);
    check("d0_59", last_seg[0], 8'h90);
    repeat (37) @(negedge clk_50M);
    set_time(5, 0, 0, 0);
    repeat (170) @(negedge clk_50M);
    check("d5_zero", last_seg[5], 8'hC0);
    check("d0_zero", last_seg[0], 8'hC0);

    set_time(2, 8, 5, 30);
    state_mode = 4'd1;
    repeat (200) @(negedge clk_50M);
    state_mode = 4'd0;

    set_time(0, 30, 60, 0);
    repeat (170) @(negedge clk_50M);
    check("oor_d5", last_seg[5], 8'hBF);
    check("oor_d4", last_seg[4], 8'h3F);
    check("oor_d3", last_seg[3], 8'hBF);
    check("oor_d2", last_seg[2], 8'h3F);
    check("oor_d7", last_seg[7], 8'hBF);

    set_time(4, 17, 42, 13);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk_50M);
      if (m_idx == 3 && m_presc == 5) found = 1'b1;
    end
    check("rst_wait", 32'(found), 32'd1);
    check("pre_rst_dig", dig_sel, 8'hF7);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", seg, 8'hFF);
    check("async_dig", dig_sel, 8'hFF);
    @(negedge clk_50M);
    rst_n = 1'b1;
    @(negedge clk_50M);
    check("rel_c1_dig", dig_sel, 8'hFF);
    @(negedge clk_50M);
    check("rel_c2_dig", dig_sel, 8'hFE);

    repeat (1000) begin
      @(negedge clk_50M);
      if ($urandom_range(0, 9) == 0)
        set_time(int'($urandom_range(1, 7)), int'($urandom_range(0, 23)),
                 int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      if ($urandom_range(0, 49) == 0) state_mode = 4'($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
